// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and
// divide-by-zero result constants.
package alu_pkg;

    // Operation select encoding on cu_aluOp.
    localparam logic [3:0] OP_PASS  = 4'h0;  // data1
    localparam logic [3:0] OP_ADD   = 4'h1;  // data1 + data2
    localparam logic [3:0] OP_SUB   = 4'h2;  // data1 - data2
    localparam logic [3:0] OP_INC   = 4'h3;  // data1 + 1
    localparam logic [3:0] OP_DEC   = 4'h4;  // data1 - 1
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_NOT   = 4'h8;  // ~data1
    localparam logic [3:0] OP_SHL   = 4'h9;  // data1 << shamt
    localparam logic [3:0] OP_SHR   = 4'hA;  // data1 >> shamt, logical
    localparam logic [3:0] OP_SLT   = 4'hB;  // 1/0, zero-extended
    localparam logic [3:0] OP_MUL   = 4'hC;  // low WIDTH bits of product
    localparam logic [3:0] OP_DIV   = 4'hD;  // unsigned quotient
    localparam logic [3:0] OP_REM   = 4'hE;  // unsigned remainder
    localparam logic [3:0] OP_PASS2 = 4'hF;  // data2

    // Controller states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    // Divide by zero: DIV returns every bit set; REM returns the dividend.
    localparam logic DBZ_QUOT_BIT = 1'b1;

    function automatic logic is_divide_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring divider, one quotient bit per step, MSB first.
// The first step is taken on the load edge from the raw inputs, so a
// WIDTH-bit divide needs the load edge plus WIDTH-1 step_en edges.
// quotient/remainder show the values produced by the step taken on the
// coming edge, letting the parent register the final result on that edge.
module alu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             step_en,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH-1:0] rem_d, quo_d;
    logic [WIDTH-1:0] rem_src, quo_src, dvs_src;

    // One restoring step: shift the next dividend bit into the partial
    // remainder, subtract when it fits, shift the quotient bit in.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0] rem,
        input logic [WIDTH-1:0] quo,
        input logic [WIDTH-1:0] dvs
    );
        logic [WIDTH:0]   trial;
        logic [WIDTH-1:0] rem_n;
        logic             q_bit;
        trial = {rem, quo[WIDTH-1]};
        if (trial >= {1'b0, dvs}) begin
            rem_n = WIDTH'(trial - {1'b0, dvs});
            q_bit = 1'b1;
        end else begin
            rem_n = trial[WIDTH-1:0];
            q_bit = 1'b0;
        end
        return {rem_n, quo[WIDTH-2:0], q_bit};
    endfunction

    // Step source: fresh operands on load, otherwise the running state.
    always_comb begin
        rem_src = load ? '0       : rem_q;
        quo_src = load ? dividend : quo_q;
        dvs_src = load ? divisor  : dvs_q;
        {rem_d, quo_d} = div_step(rem_src, quo_src, dvs_src);
    end

    // Divider state: advance on load or step_en, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            if (load || step_en) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
            end
            if (load) begin
                dvs_q <= divisor;
            end
        end
    end

    assign quotient  = quo_d;
    assign remainder = rem_d;

endmodule

// File: rtl/seq_alu.sv
// Clocked ALU with start/done handshake. Single-cycle ops complete on the
// accepting edge; MUL (shift-add) and DIV/REM (restoring) iterate one bit
// per cycle.
//
// Handshake: start is sampled on a rising edge only while busy=0; that edge
// latches all operands. done pulses for exactly one cycle when aluOut and
// the flags update; busy covers the remaining cycles of a multi-cycle op and
// is never high together with done. start in the done cycle is accepted.
import alu_pkg::*;

module seq_alu #(
    parameter int WIDTH      = 32,
    parameter int SHAMT_W    = 5,
    parameter bit SIGNED_SLT = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         cu_aluOp,
    input  logic [WIDTH-1:0]   data1,
    input  logic [WIDTH-1:0]   data2,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   aluOut,
    output logic               zero,
    output logic               negative,
    output logic               div_by_zero,
    output state_t             dbg_state
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 2);

    state_t           state_q;
    logic             busy_q, done_q, zero_q, neg_q, dbz_q, is_rem_q;
    logic [WIDTH-1:0] alu_out_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;

    logic [WIDTH-1:0] single_res, mul_acc_d, res_d;
    logic [WIDTH-1:0] div_quot, div_rem;
    logic             slt_lt, d2_zero, div_load, div_step_en;

    // Result for every op that completes on the accepting edge.
    always_comb begin
        slt_lt  = SIGNED_SLT ? ($signed(data1) < $signed(data2)) : (data1 < data2);
        d2_zero = (data2 == '0);
        single_res = '0;
        case (cu_aluOp)
            OP_PASS:  single_res = data1;
            OP_ADD:   single_res = data1 + data2;
            OP_SUB:   single_res = data1 - data2;
            OP_INC:   single_res = data1 + WIDTH'(1);
            OP_DEC:   single_res = data1 - WIDTH'(1);
            OP_AND:   single_res = data1 & data2;
            OP_OR:    single_res = data1 | data2;
            OP_XOR:   single_res = data1 ^ data2;
            OP_NOT:   single_res = ~data1;
            OP_SHL:   single_res = data1 << shamt;
            OP_SHR:   single_res = data1 >> shamt;
            OP_SLT:   single_res = {{(WIDTH-1){1'b0}}, slt_lt};
            OP_DIV:   single_res = {WIDTH{DBZ_QUOT_BIT}};
            OP_REM:   single_res = data1;
            OP_PASS2: single_res = data2;
            default:  single_res = '0;
        endcase
    end

    // Next shift-add accumulator and the value registered on completion.
    always_comb begin
        mul_acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        res_d = single_res;
        if (state_q == S_MUL) begin
            res_d = mul_acc_d;
        end else if (state_q == S_DIV) begin
            res_d = is_rem_q ? div_rem : div_quot;
        end
    end

    assign div_load    = (state_q == S_IDLE) && start && is_divide_op(cu_aluOp) && !d2_zero;
    assign div_step_en = (state_q == S_DIV);

    alu_divider #(.WIDTH(WIDTH)) u_divider (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (div_load),
        .dividend  (data1),
        .divisor   (data2),
        .step_en   (div_step_en),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    // Controller: accept, iterate, complete; all outputs registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            alu_out_q <= '0;
            zero_q    <= 1'b1;
            neg_q     <= 1'b0;
            dbz_q     <= 1'b0;
            is_rem_q  <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (cu_aluOp == OP_MUL) begin
                            // First partial product is folded into the accept edge.
                            state_q  <= S_MUL;
                            busy_q   <= 1'b1;
                            acc_q    <= data2[0] ? data1 : '0;
                            mcand_q  <= data1 << 1;
                            mplier_q <= data2 >> 1;
                            cnt_q    <= CNT_LOAD;
                        end else if (div_load) begin
                            state_q  <= S_DIV;
                            busy_q   <= 1'b1;
                            is_rem_q <= (cu_aluOp == OP_REM);
                            cnt_q    <= CNT_LOAD;
                        end else begin
                            done_q    <= 1'b1;
                            alu_out_q <= res_d;
                            zero_q    <= (res_d == '0);
                            neg_q     <= res_d[WIDTH-1];
                            dbz_q     <= is_divide_op(cu_aluOp) && d2_zero;
                        end
                    end
                end
                S_MUL: begin
                    acc_q    <= mul_acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        alu_out_q <= res_d;
                        zero_q    <= (res_d == '0);
                        neg_q     <= res_d[WIDTH-1];
                        dbz_q     <= 1'b0;
                    end
                end
                S_DIV: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        alu_out_q <= res_d;
                        zero_q    <= (res_d == '0);
                        neg_q     <= res_d[WIDTH-1];
                        dbz_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign aluOut      = alu_out_q;
    assign zero        = zero_q;
    assign negative    = neg_q;
    assign div_by_zero = dbz_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu with a transaction-level reference model.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    op = 4'h0;
    logic [W-1:0]  d1 = '0, d2 = '0;
    logic [SW-1:0] sh = '0;
    logic          busy, done, zero, negative, dbz;
    logic [W-1:0]  alu_out;
    state_t        dbg_state;

    int  tests = 0;
    int  fails = 0;
    bit  checking = 1'b0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W), .SHAMT_W(SW), .SIGNED_SLT(1'b0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cu_aluOp    (op),
        .data1       (d1),
        .data2       (d2),
        .shamt       (sh),
        .busy        (busy),
        .done        (done),
        .aluOut      (alu_out),
        .zero        (zero),
        .negative    (negative),
        .div_by_zero (dbz),
        .dbg_state   (dbg_state)
    );

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model_calc(input logic [3:0] o, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input logic [SW-1:0] s);
        logic [W-1:0] r;
        case (o)
            4'h0: r = a;
            4'h1: r = a + b;
            4'h2: r = a - b;
            4'h3: r = a + 1;
            4'h4: r = a - 1;
            4'h5: r = a & b;
            4'h6: r = a | b;
            4'h7: r = a ^ b;
            4'h8: r = ~a;
            4'h9: r = a << s;
            4'hA: r = a >> s;
            4'hB: r = (a < b) ? W'(1) : W'(0);
            4'hC: r = a * b;
            4'hD: r = (b == 0) ? {W{1'b1}} : a / b;
            4'hE: r = (b == 0) ? a : a % b;
            default: r = b;
        endcase
        return r;
    endfunction

    // Model state: held outputs, done pulse, one pending multi-cycle op.
    logic [W-1:0] m_out, p_res, f_res;
    logic         m_zero, m_neg, m_dbz, m_done, m_pend, p_dbz, f_dbz, fin;
    longint       edge_n, fin_edge;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out = '0; m_zero = 1'b1; m_neg = 1'b0; m_dbz = 1'b0;
            m_done = 1'b0; m_pend = 1'b0; edge_n = 0; fin_edge = 0;
        end else begin
            edge_n = edge_n + 1;
            m_done = 1'b0;
            fin = 1'b0;
            f_res = '0;
            f_dbz = 1'b0;
            if (m_pend) begin
                if (edge_n == fin_edge) begin
                    m_pend = 1'b0; fin = 1'b1; f_res = p_res; f_dbz = p_dbz;
                end
            end else if (start) begin
                if (op == 4'hC || ((op == 4'hD || op == 4'hE) && d2 != 0)) begin
                    m_pend = 1'b1;
                    fin_edge = edge_n + W - 1;
                    p_res = model_calc(op, d1, d2, sh);
                    p_dbz = 1'b0;
                end else begin
                    fin = 1'b1;
                    f_res = model_calc(op, d1, d2, sh);
                    f_dbz = (op == 4'hD || op == 4'hE) && d2 == 0;
                end
            end
            if (fin) begin
                m_out = f_res; m_zero = (f_res == 0); m_neg = f_res[W-1];
                m_dbz = f_dbz; m_done = 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle, away from the active edge, compare all outputs to the model.
    always @(negedge clk) begin
        if (checking) begin
            check("cmp_busy",   W'(busy),     W'(m_pend));
            check("cmp_done",   W'(done),     W'(m_done));
            check("cmp_aluOut", alu_out,      m_out);
            check("cmp_zero",   W'(zero),     W'(m_zero));
            check("cmp_neg",    W'(negative), W'(m_neg));
            check("cmp_dbz",    W'(dbz),      W'(m_dbz));
        end
    end

    // ---------------- driver tasks ----------------
    // Present an op at a negedge; it is accepted on the following posedge.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [SW-1:0] s);
        @(negedge clk);
        start = 1'b1; op = o; d1 = a; d2 = b; sh = s;
        @(posedge clk);
    endtask

    // Count cycles after acceptance until done; operands are scrambled
    // meanwhile since the op in flight must not depend on them.
    task automatic wait_done(input int max, input string name, output int k);
        k = 0;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            start = 1'b0;
            d1 = $urandom;
            d2 = $urandom;
            if (done) begin
                k = i;
                break;
            end
        end
        if (k == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: no done within %0d cycles", name, max);
        end
    endtask

    // ---------------- directed stimulus ----------------
    logic [3:0]    t_op  [13] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
                                  4'hA, 4'hB, 4'hB, 4'hF, 4'h0, 4'hE};
    logic [W-1:0]  t_a   [13] = '{32'd5, 32'hFFFFFFFF, 32'd0, 32'hF0F01234, 32'hF0000000,
                                  32'hAAAA5555, 32'h0000FFFF, 32'h80000000, 32'd3, 32'd7,
                                  32'd9, 32'hDEADBEEF, 32'h00001234};
    logic [W-1:0]  t_b   [13] = '{32'd7, 32'd0, 32'd0, 32'h0FF0FF00, 32'h0000000F,
                                  32'hFFFF0000, 32'd0, 32'd0, 32'h80000000, 32'd7,
                                  32'h12345678, 32'd1, 32'd0};
    logic [SW-1:0] t_s   [13] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
                                  5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [W-1:0]  t_exp [13] = '{32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 32'h00F01200, 32'hF000000F,
                                  32'h55555555, 32'hFFFF0000, 32'h08000000, 32'd1, 32'd0,
                                  32'h12345678, 32'hDEADBEEF, 32'h00001234};

    initial begin
        int k;
        // Reset asserted mid-cycle: outputs must clear without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_aluOut", alu_out, 32'h0);
        check("rst_zero",   W'(zero), 32'd1);
        check("rst_busy",   W'(busy), 32'd0);
        check("rst_done",   W'(done), 32'd0);
        check("rst_dbz",    W'(dbz),  32'd0);
        check("rst_state",  W'(dbg_state), W'(S_IDLE));
        checking = 1'b1;
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_no_done", W'(done), 32'd0);
        end

        // Single-cycle add with wrap to zero, then shift into the sign bit.
        issue(4'h1, 32'hFFFFFFFF, 32'd1, 5'd0);
        wait_done(40, "add", k);
        check("add_lat", W'(k), 32'd1);
        check("add_out", alu_out, 32'h0);
        check("add_zero", W'(zero), 32'd1);
        issue(4'h9, 32'd1, 32'd0, 5'd31);
        wait_done(40, "shl", k);
        check("shl_out", alu_out, 32'h80000000);
        check("shl_neg", W'(negative), 32'd1);

        // Remaining single-cycle ops, each pinned by a hand-computed value.
        for (int i = 0; i < 13; i++) begin
            issue(t_op[i], t_a[i], t_b[i], t_s[i]);
            wait_done(40, "tbl", k);
            check("tbl_lat", W'(k), 32'd1);
            check("tbl_out", alu_out, t_exp[i]);
        end

        // Multiply: operands scrambled while busy.
        issue(4'hC, 32'h00010003, 32'h00020005, 5'd0);
        wait_done(40, "mul", k);
        check("mul_lat", W'(k), 32'd32);
        check("mul_out", alu_out, 32'h000B000F);

        // Divide / remainder / divide by zero / flag clear.
        issue(4'hD, 32'd100, 32'd7, 5'd0);
        wait_done(40, "div", k);
        check("div_lat", W'(k), 32'd32);
        check("div_out", alu_out, 32'd14);
        issue(4'hE, 32'd100, 32'd7, 5'd0);
        wait_done(40, "rem", k);
        check("rem_lat", W'(k), 32'd32);
        check("rem_out", alu_out, 32'd2);
        issue(4'hD, 32'd100, 32'd0, 5'd0);
        wait_done(40, "div0", k);
        check("div0_lat", W'(k), 32'd1);
        check("div0_out", alu_out, 32'hFFFFFFFF);
        check("div0_flag", W'(dbz), 32'd1);
        issue(4'h1, 32'd1, 32'd2, 5'd0);
        wait_done(40, "clr", k);
        check("clr_out", alu_out, 32'd3);
        check("clr_flag", W'(dbz), 32'd0);

        // start held through a MUL with an ADD presented: ignored while busy,
        // accepted in the done cycle for a back-to-back completion.
        issue(4'hC, 32'h00010003, 32'h00020005, 5'd0);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            op = 4'h1; d1 = 32'd3; d2 = 32'd4;
            if (done) begin
                k = i;
                break;
            end
        end
        check("hold_lat", W'(k), 32'd32);
        check("hold_mul", alu_out, 32'h000B000F);
        wait_done(5, "b2b", k);
        check("b2b_lat", W'(k), 32'd1);
        check("b2b_out", alu_out, 32'd7);

        // Reset pulse in the middle of a divide aborts it silently.
        issue(4'hD, 32'd100, 32'd7, 5'd0);
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            check("abort_pre", W'(done), 32'd0);
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", W'(busy), 32'd0);
        check("abort_out", alu_out, 32'h0);
        #1 rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            check("abort_quiet", W'(done), 32'd0);
        end
        issue(4'h0, 32'd5, 32'd0, 5'd0);
        wait_done(40, "post_abort", k);
        check("post_lat", W'(k), 32'd1);
        check("post_out", alu_out, 32'd5);

        repeat (2) @(negedge clk);
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard bound on total run time.
    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
